// File: rtl/scpu_pkg.sv
// Shared definitions for the sound-CPU memory window logic.
package scpu_pkg;

  // Width of the hps_io ioctl byte address
  localparam int IOCTL_AW = 27;

  // Byte returned for addresses outside the RAM window
  localparam logic [7:0] FILL_DEFAULT = 8'hFF;

  // Upload reader states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } upl_state_t;

endpackage

// File: rtl/scpu_ram_upload.sv
// Upload-side reader for the sound-CPU RAM window.
// Each ioctl read fetches bytes A and A+1 from the external 8-bit synchronous
// RAM and returns them as one 16-bit word. While an upload session is open the
// CPU is held off the RAM, and the RAM address port reverts to cpu_ab whenever
// no fetch is driving it.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for ioctl_rd; out-of-window reads answered here
// LO    | byte A address on mem_addr
// HI    | byte A+1 address on mem_addr; byte A arrives on mem_q
// DONE  | byte A+1 arrives on mem_q; word registered to ioctl_din
module scpu_ram_upload
  import scpu_pkg::*;
#(
  parameter int                  ADDR_W = 13,
  parameter logic [IOCTL_AW-1:0] BASE   = 27'h8000,
  parameter logic [7:0]          FILL   = FILL_DEFAULT
) (
  input  logic                clk_sys,
  input  logic                reset_n,
  input  logic                ioctl_upload,
  input  logic [IOCTL_AW-1:0] ioctl_addr,
  input  logic                ioctl_rd,
  output logic [15:0]         ioctl_din,
  output logic                ioctl_wait,
  input  logic [15:0]         cpu_ab,
  output logic                cpu_hold,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic [7:0]          mem_q
);

  // One past the last ioctl byte address inside the window; an extra bit
  // keeps the compare exact when the window touches the top of ioctl space.
  localparam logic [IOCTL_AW:0] WIN_END =
    {1'b0, BASE} + ({{IOCTL_AW{1'b0}}, 1'b1} << ADDR_W);

  upl_state_t state, state_nxt;

  logic [IOCTL_AW-1:0] req_addr;
  logic [IOCTL_AW-1:0] req_rel;
  logic                in_win;
  logic [ADDR_W-1:0]   off_q;
  logic [7:0]          lo_q;
  logic [15:0]         din_q;
  logic                hold_q;

  // Word address of the request (bit 0 dropped) and its offset into the window
  assign req_addr = {ioctl_addr[IOCTL_AW-1:1], 1'b0};
  assign req_rel  = req_addr - BASE;
  assign in_win   = (req_addr >= BASE) && ({1'b0, req_addr} < WIN_END);

  // Only the low ADDR_W offset bits and low cpu_ab bits reach the RAM
  logic unused_bits;
  assign unused_bits = ^{ioctl_addr[0], cpu_ab, req_rel};

  // State register
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next state: a fetch is a fixed three-cycle walk; requests outside IDLE are dropped
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ioctl_rd && in_win) state_nxt = LO;
      LO:      state_nxt = HI;
      HI:      state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // RAM address mux: fetch address only while a byte address is being presented
  always_comb begin
    mem_addr = cpu_ab[ADDR_W-1:0];
    case (state)
      LO:      mem_addr = off_q;
      HI:      mem_addr = off_q + ADDR_W'(1);
      default: mem_addr = cpu_ab[ADDR_W-1:0];
    endcase
  end

  // Offset latch, byte assembly and returned word
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      off_q <= '0;
      lo_q  <= '0;
      din_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ioctl_rd) begin
            if (in_win) off_q <= req_rel[ADDR_W-1:0];
            else        din_q <= {FILL, FILL};
          end
        end
        HI:      lo_q  <= mem_q;
        DONE:    din_q <= {mem_q, lo_q};
        default: ;
      endcase
    end
  end

  // CPU hold: set while uploading, released only once any fetch has drained
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n)               hold_q <= 1'b0;
    else if (ioctl_upload)      hold_q <= 1'b1;
    else if (state == IDLE)     hold_q <= 1'b0;
  end

  assign ioctl_din  = din_q;
  assign ioctl_wait = (state != IDLE);
  assign cpu_hold   = hold_q;

endmodule

// File: tb/tb_scpu_ram_upload.sv
// Bench for scpu_ram_upload: random and directed ioctl reads against a
// byte-array RAM model, with a queue-based scoreboard and a separate monitor.
module tb_scpu_ram_upload;

  localparam int ADDR_W = 13;
  localparam int WIN    = 1 << ADDR_W;
  localparam int BASE   = 'h8000;

  logic        clk_sys      = 1'b0;
  logic        reset_n      = 1'b0;
  logic        ioctl_upload = 1'b0;
  logic [26:0] ioctl_addr   = '0;
  logic        ioctl_rd     = 1'b0;
  logic [15:0] ioctl_din;
  logic        ioctl_wait;
  logic [15:0] cpu_ab       = '0;
  logic        cpu_hold;
  logic [12:0] mem_addr;
  logic [7:0]  mem_q;

  logic [7:0]  ram [WIN];

  typedef struct {
    bit          in_win;
    logic [12:0] off;
    logic [15:0] word;
  } exp_t;

  exp_t sb_q[$];
  int   checks    = 0;
  int   failures  = 0;
  bit   mon_en    = 1'b1;
  logic prev_wait = 1'b0;

  scpu_ram_upload dut (
    .clk_sys      (clk_sys),
    .reset_n      (reset_n),
    .ioctl_upload (ioctl_upload),
    .ioctl_addr   (ioctl_addr),
    .ioctl_rd     (ioctl_rd),
    .ioctl_din    (ioctl_din),
    .ioctl_wait   (ioctl_wait),
    .cpu_ab       (cpu_ab),
    .cpu_hold     (cpu_hold),
    .mem_addr     (mem_addr),
    .mem_q        (mem_q)
  );

  always #5 clk_sys = ~clk_sys;

  // External synchronous RAM, read-only from this block's point of view
  always @(posedge clk_sys) mem_q <= ram[mem_addr];

  // CPU address bus wanders every cycle so the mux is exercised
  initial begin
    forever begin
      @(posedge clk_sys);
      #1;
      cpu_ab = 16'($urandom);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached before end of test, expected $finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: a word is two bytes at the even address, or FILL outside the window
  function automatic exp_t model(input logic [26:0] a);
    exp_t e;
    int   w;
    w        = int'(a) & ~1;
    e.in_win = (w >= BASE) && (w < BASE + WIN);
    e.off    = 13'(w - BASE);
    e.word   = 16'hFFFF;
    if (e.in_win) e.word = {ram[13'(e.off + 13'd1)], ram[e.off]};
    return e;
  endfunction

  task automatic check_response(input exp_t e);
    int cnt;
    cnt = 0;
    if (e.in_win) begin
      for (int i = 0; i < 8; i++) begin
        @(negedge clk_sys);
        if (!ioctl_wait) break;
        cnt++;
        if (cnt == 1)      chk("addr_byte_a", 32'(mem_addr), 32'(e.off));
        else if (cnt == 2) chk("addr_byte_a1", 32'(mem_addr), 32'(e.off) + 1);
        else               chk("addr_done_cpu", 32'(mem_addr), 32'(cpu_ab[12:0]));
      end
      chk("wait_cycles", cnt, 3);
      chk("word", 32'(ioctl_din), 32'(e.word));
    end else begin
      @(negedge clk_sys);
      chk("oow_wait", 32'(ioctl_wait), 0);
      chk("oow_word", 32'(ioctl_din), 32'(e.word));
      chk("oow_mux", 32'(mem_addr), 32'(cpu_ab[12:0]));
    end
  endtask

  // Monitor: a read seen while the block is idle is paired with the oldest expectation
  initial begin
    forever begin
      @(negedge clk_sys);
      if (reset_n && mon_en) begin
        if (ioctl_rd && !ioctl_wait) begin
          chk("sb_has_entry", 32'(sb_q.size() != 0), 1);
          if (sb_q.size() != 0) check_response(sb_q.pop_front());
        end else begin
          chk("spurious_fetch", 32'(ioctl_wait && !prev_wait), 0);
        end
      end
      prev_wait = ioctl_wait;
    end
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic issue(input logic [26:0] a, input bit dbl);
    tick();
    ioctl_addr = a;
    ioctl_rd   = 1'b1;
    if (mon_en) sb_q.push_back(model(a));
    tick();
    if (dbl) tick();
    ioctl_rd = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (ioctl_wait && n < 10) begin
      tick();
      n++;
    end
    chk("idle_timeout", 32'(ioctl_wait), 0);
  endtask

  function automatic logic [26:0] rand_addr();
    logic [26:0] bnd [8];
    bnd[0] = 27'h8000; bnd[1] = 27'h8001; bnd[2] = 27'h9FFE; bnd[3] = 27'h9FFF;
    bnd[4] = 27'h7FFE; bnd[5] = 27'h7FFF; bnd[6] = 27'hA000; bnd[7] = 27'hA001;
    case ($urandom_range(0, 3))
      0, 1:    return 27'(BASE + int'($urandom_range(0, WIN - 1)));
      2:       return bnd[$urandom_range(0, 7)];
      default: return 27'($urandom);
    endcase
  endfunction

  initial begin
    for (int i = 0; i < WIN; i++) ram[i] = 8'($urandom);
    ram[0]     = 8'h34;
    ram[1]     = 8'h12;
    ram['h1FFE] = 8'hAA;
    ram['h1FFF] = 8'hBB;

    // Reset values
    repeat (3) tick();
    chk("rst_din", 32'(ioctl_din), 0);
    chk("rst_wait", 32'(ioctl_wait), 0);
    chk("rst_hold", 32'(cpu_hold), 0);
    chk("rst_mux", 32'(mem_addr), 32'(cpu_ab[12:0]));
    @(negedge clk_sys);
    reset_n = 1'b1;

    // Hold rises one cycle after upload
    tick();
    ioctl_upload = 1'b1;
    @(negedge clk_sys);
    chk("hold_before_edge", 32'(cpu_hold), 0);
    tick();
    chk("hold_rise", 32'(cpu_hold), 1);

    // Directed reads: first word, top-of-window word, two out-of-window words
    issue(27'h8000, 1'b0); wait_idle();
    issue(27'h9FFF, 1'b0); wait_idle();
    issue(27'h7FFE, 1'b0); wait_idle();
    issue(27'hA000, 1'b0); wait_idle();
    chk("hold_during_upload", 32'(cpu_hold), 1);

    // Upload drops while in HI: fetch completes, hold falls one cycle after return to IDLE
    issue(27'(BASE + 2 * int'($urandom_range(0, WIN / 2 - 1))), 1'b0);
    tick();
    ioctl_upload = 1'b0;
    tick();
    chk("hold_in_done", 32'(cpu_hold), 1);
    tick();
    chk("hold_at_idle", 32'(cpu_hold), 1);
    chk("idle_after_drop", 32'(ioctl_wait), 0);
    tick();
    chk("hold_fall", 32'(cpu_hold), 0);

    // Reads without an upload session are still served; hold stays low
    for (int i = 0; i < 4; i++) begin
      issue(rand_addr(), 1'b0);
      wait_idle();
      chk("hold_no_upload", 32'(cpu_hold), 0);
    end

    tick();
    ioctl_upload = 1'b1;
    tick();
    chk("hold_rise_again", 32'(cpu_hold), 1);

    // Second read pulse during LO is dropped
    issue(27'(BASE + int'($urandom_range(0, WIN - 1))), 1'b1);
    wait_idle();
    tick();
    chk("dbl_no_refetch", 32'(ioctl_wait), 0);

    // Random traffic
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 2)) tick();
      issue(rand_addr(), 1'b0);
      wait_idle();
    end

    // Make sure the returned word is non-zero so the reset clear is visible
    ram[2] = 8'h5A;
    issue(27'h8002, 1'b0);
    wait_idle();

    // Reset in the middle of a fetch
    mon_en = 1'b0;
    issue(27'(BASE + 2 * int'($urandom_range(0, WIN / 2 - 1))), 1'b0);
    tick();
    chk("busy_before_reset", 32'(ioctl_wait), 1);
    reset_n = 1'b0;
    #1;
    chk("midrst_wait", 32'(ioctl_wait), 0);
    chk("midrst_hold", 32'(cpu_hold), 0);
    chk("midrst_din", 32'(ioctl_din), 0);
    chk("midrst_mux", 32'(mem_addr), 32'(cpu_ab[12:0]));
    @(negedge clk_sys);
    reset_n = 1'b1;
    tick();
    mon_en = 1'b1;
    tick();
    chk("hold_after_reset", 32'(cpu_hold), 1);
    issue(27'(BASE + int'($urandom_range(0, WIN - 1))), 1'b0);
    wait_idle();
    issue(27'h8000, 1'b0);
    wait_idle();

    repeat (3) tick();
    chk("sb_drained", 32'(sb_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/scpu_ram_upload.md
# scpu_ram_upload

Upload-side reader for the sound-CPU memory window: serves HPS `ioctl` upload reads by fetching two consecutive bytes from the shared 8-bit synchronous RAM and returning them as one 16-bit word on `ioctl_din`. It owns the RAM address port during an upload, freezes the CPU while it does so, and hands the port back to `cpu_ab` afterwards. It sits between `hps_io` and the existing single-port `ram` instance, which stays outside this block.

## Interface
- `ADDR_W`, 13: RAM address width; the window size is 2**ADDR_W bytes.
- `BASE`, 27'h8000: byte address of RAM location 0 in `ioctl` space.
- `FILL`, 8'hFF: byte returned for addresses outside the window.

Ports:
- `clk_sys` in 1: system clock; all logic on the rising edge.
- `reset_n` in 1: asynchronous active-low reset.
- `ioctl_upload` in 1: upload session active.
- `ioctl_addr` in 27: byte address of the requested word. Bit 0 is ignored.
- `ioctl_rd` in 1: one-cycle read request.
- `ioctl_din` out 16: returned word. `[7:0]` holds byte A and `[15:8]` holds byte A+1.
- `ioctl_wait` out 1: high while a fetch is in flight.
- `cpu_ab` in 16: CPU address bus.
- `cpu_hold` out 1: halts the CPU while the block owns the RAM.
- `mem_addr` out ADDR_W: RAM address. It is `cpu_ab[ADDR_W-1:0]` when the block does not own the RAM.
- `mem_q` in 8: RAM read data, valid the cycle after its address is presented.

## Operation
- States: IDLE, LO, HI, DONE.
- **IDLE, in-window request.** On `ioctl_rd` with `BASE <= {ioctl_addr[26:1],1'b0} < BASE+2**ADDR_W`:
  - latch `off = ({ioctl_addr[26:1],1'b0} - BASE)[ADDR_W-1:0]`;
  - go to LO.
- **IDLE, out-of-window request.**
  - Load `ioctl_din = {FILL,FILL}` on the next edge.
  - No RAM access and no `ioctl_wait`.
- **LO:** drive `mem_addr = off`, then go to HI.
- **HI:** drive `mem_addr = off+1`, capture `mem_q` (byte A) into the low byte, then go to DONE.
- **DONE:** capture `mem_q` (byte A+1) into the high byte, register `ioctl_din`, then go to IDLE.
- `off` is always even, so `off+1` never leaves the window (no wrap).
- **Address mux:**
  - `mem_addr` selects the fetch address in states LO and HI;
  - it selects `cpu_ab` otherwise, including while `cpu_hold` is high and IDLE.
- **`cpu_hold`:**
  - set on the edge after `ioctl_upload` goes high;
  - cleared on the first edge where `ioctl_upload` is low and the state is IDLE;
  - a fetch in progress when `ioctl_upload` drops always completes.
- `ioctl_rd` while not IDLE is ignored and does not queue.
- `ioctl_rd` while `ioctl_upload` is low is still serviced. The mux guarantees port ownership; `cpu_hold` stays low.
- The block never writes the RAM.

## Timing
- **Reset values:**
  - state IDLE;
  - `ioctl_din` 16'h0000;
  - `ioctl_wait` 0;
  - `cpu_hold` 0;
  - `mem_addr` follows `cpu_ab`.
- **Reset mid-fetch:** abort immediately to the reset values; no partial word is presented.
- **In-window latency.** With `ioctl_rd` sampled at edge 0:
  - `ioctl_wait` is high from edge 0 to edge 3;
  - `ioctl_din` is valid after edge 3, together with `ioctl_wait` falling;
  - the next request is accepted at edge 3.
- **Out-of-window latency:** `ioctl_din` is valid after edge 0 and `ioctl_wait` stays 0.
- **Hold timing:**
  - `cpu_hold` rises 1 cycle after `ioctl_upload` rises;
  - `cpu_hold` falls 1 cycle after the later of `ioctl_upload` low or DONE→IDLE.
- `ioctl_din` holds its last value until the next completed request.

## Structure
- Shared package `scpu_pkg` holds:
  - the state enum `upl_state_t` (IDLE, LO, HI, DONE);
  - the `FILL` default constant;
  - the `ioctl` address width constant (27).
- No sub-module. The FSM, byte-assembly registers and address mux are one flat block; the RAM stays external.

## Test plan
- Preload RAM[0]=8'h34 and RAM[1]=8'h12. Assert `ioctl_upload`, then pulse `ioctl_rd` at `ioctl_addr`=27'h8000 → `ioctl_din`=16'h1234 after edge 3, `ioctl_wait` high for exactly 3 cycles, `mem_addr` sequence 0 then 1.
- Request `ioctl_addr`=27'h9FFF with RAM[1FFE]=8'hAA and RAM[1FFF]=8'hBB → bit 0 is ignored and `ioctl_din`=16'hBBAA; no wrap to address 0.
- Request `ioctl_addr`=27'h7FFE and then 27'hA000 → each returns 16'hFFFF one cycle later, with no `ioctl_wait` and `mem_addr` equal to `cpu_ab`.
- Drop `ioctl_upload` during state HI → the fetch completes with correct data, then `cpu_hold` falls 1 cycle after DONE→IDLE.
- Pulse `ioctl_rd` again during LO → it is ignored; exactly one word is returned and the FSM is idle after 3 cycles.
- Assert `reset_n` low during HI → on that cycle state is IDLE, `ioctl_wait`=0, `cpu_hold`=0, `ioctl_din`=0; after release, a fresh request returns correct data.
